// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for wide_add_seq: FSM state encodings and default width constants.
package wide_add_seq_pkg;

    localparam int WA_WIDTH_DEF = 64;
    localparam int WA_SLICE_DEF = 16;

    typedef enum logic [1:0] {
        WA_IDLE = 2'd0,
        WA_RUN  = 2'd1,
        WA_DONE = 2'd2
    } wa_state_t;

endpackage

// File: rtl/wide_add_seq_cla_slice.sv
// cla_slice: combinational SLICE-bit carry-lookahead adder built from 4-bit CLA groups.
module cla_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    localparam int NG = SLICE / 4;

    // gc[k] is the carry into group k; groups chain through their generate/propagate pair.
    logic [NG:0] gc;

    assign gc[0] = cin;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       grp_g;
        logic       grp_p;

        assign g = a[4*k +: 4] & b[4*k +: 4];
        assign p = a[4*k +: 4] ^ b[4*k +: 4];

        assign c[0] = gc[k];
        assign c[1] = g[0] | (p[0] & gc[k]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc[k]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & gc[k]);

        assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]);
        assign grp_p = &p;

        assign gc[k+1]    = grp_g | (grp_p & gc[k]);
        assign s[4*k +: 4] = p ^ c;
    end

    assign cout = gc[NG];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder/subtractor: one SLICE-bit CLA slice per cycle, LS slice first.
// Optional signed-overflow output enabled by defining WIDE_ADD_OVF_EN.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int WIDTH = WA_WIDTH_DEF,
    parameter int SLICE = WA_SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef WIDE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NS   = WIDTH / SLICE;
    localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is high only in IDLE; out_valid is high only in DONE.

    wa_state_t        state;
    wa_state_t        state_next;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_c;
    logic             last;

    assign last = (idx == IDXW'(NS - 1));

    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (op_a[idx*SLICE +: SLICE]),
        .b    (op_b[idx*SLICE +: SLICE]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            WA_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = WA_RUN;
            end
            WA_RUN: begin
                if (last) state_next = WA_DONE;
            end
            WA_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = WA_IDLE;
            end
            default: state_next = WA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WA_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                WA_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, so the incoming cin is dropped.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        sum   <= '0;
                        idx   <= '0;
                    end
                end
                WA_RUN: begin
                    sum[idx*SLICE +: SLICE] <= slice_s;
                    carry                   <= slice_c;
                    if (last) begin
                        cout <= slice_c;
`ifdef WIDE_ADD_OVF_EN
                        ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                                (slice_s[SLICE-1] != op_a[WIDTH-1]);
`endif
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WIDTH=64, SLICE=16); checks ovf when WIDE_ADD_OVF_EN is defined.
module tb_wide_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
`ifdef WIDE_ADD_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wide_add_seq #(
        .WIDTH (64),
        .SLICE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef WIDE_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [63:0] aa, input logic [63:0] bb,
                            input logic c, input logic s);
        a        = aa;
        b        = bb;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          waited;
        int          acc;
        int          prev_acc;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] eff_b;
        logic        rc;
        logic        rs;
        logic [64:0] t;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (3) tick();

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
`ifdef WIDE_ADD_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b0;
        tick();

        // Carry out of the low 32 bits into slice 2
        start_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        check("t1_busy", 64'(in_ready), 64'd0);
        wait_result(lat);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_sum", sum, 64'h0000_0001_0000_0000);
        check("t1_cout", 64'(cout), 64'd0);
`ifdef WIDE_ADD_OVF_EN
        check("t1_ovf", 64'(ovf), 64'd0);
`endif
        finish_result();
        check("t1_out_valid_drop", 64'(out_valid), 64'd0);
        check("t1_in_ready_back", 64'(in_ready), 64'd1);

        // Wrap: cin ripples through every slice
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        wait_result(lat);
        check("t2_latency", 64'(lat), 64'd4);
        check("t2_sum", sum, 64'd0);
        check("t2_cout", 64'(cout), 64'd1);
        finish_result();

        // Subtract with cin ignored
        start_op(64'd5, 64'd7, 1'b1, 1'b1);
        wait_result(lat);
        check("t3_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t3_cout", 64'(cout), 64'd0);
`ifdef WIDE_ADD_OVF_EN
        check("t3_ovf", 64'(ovf), 64'd0);
`endif
        finish_result();

        start_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        wait_result(lat);
        check("t3b_sum", sum, 64'h7FFF_FFFF_FFFF_FFFF);
        check("t3b_cout", 64'(cout), 64'd1);
`ifdef WIDE_ADD_OVF_EN
        check("t3b_ovf", 64'(ovf), 64'd1);
`endif
        finish_result();

        // Backpressure in DONE with a pending request
        start_op(64'd3, 64'd4, 1'b0, 1'b0);
        wait_result(lat);
        check("t4_latency", 64'(lat), 64'd4);
        a        = 64'h1234_5678_9ABC_DEF0;
        b        = 64'h1111_1111_1111_1111;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_ready", 64'(in_ready), 64'd0);
            check("t4_hold_sum", sum, 64'd7);
            check("t4_hold_cout", 64'(cout), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_release_valid", 64'(out_valid), 64'd0);
        check("t4_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("t4_next_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_result(lat);
        check("t4_next_latency", 64'(lat), 64'd4);
        check("t4_next_sum", sum, 64'h2345_6789_ABCD_F001);
        check("t4_next_cout", 64'(cout), 64'd0);
        finish_result();

        // Reset while idx==2
        start_op(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_sum", sum, 64'd0);
        check("t5_cout", 64'(cout), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_result", 64'(out_valid), 64'd0);
        end
        start_op(64'd10, 64'd20, 1'b0, 1'b0);
        wait_result(lat);
        check("t5_after_latency", 64'(lat), 64'd4);
        check("t5_after_sum", sum, 64'd30);
        check("t5_after_cout", 64'(cout), 64'd0);
        finish_result();

        // Back-to-back with in_valid and out_ready tied high
        prev_acc  = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rc  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            a   = ra;
            b   = rb;
            cin = rc;
            sub = rs;
            waited = 0;
            while (in_ready !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            check("t6_ready", 64'(in_ready), 64'd1);
            tick();
            acc = cyc;
            if (i > 0) check("t6_period", 64'(acc - prev_acc), 64'd6);
            prev_acc = acc;
            eff_b = rs ? ~rb : rb;
            t     = {1'b0, ra} + {1'b0, eff_b} + 65'(rs ? 1'b1 : rc);
            wait_result(lat);
            check("t6_latency", 64'(lat), 64'd4);
            check("t6_sum", sum, t[63:0]);
            check("t6_cout", 64'(cout), 64'(t[64]));
`ifdef WIDE_ADD_OVF_EN
            check("t6_ovf", 64'(ovf),
                  64'((ra[63] == eff_b[63]) & (t[63] != ra[63])));
`endif
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
